// File: rtl/board_ctrl_pkg.sv
// Shared constants and helpers for the board control front-end:
// switch bit positions and the rate-to-divisor mapping.
package board_ctrl_pkg;

    // Positions of the control fields inside the raw switch bank
    localparam int SW_GO      = 0;
    localparam int SW_RST     = 1;
    localparam int SW_RATE    = 2;
    localparam int SW_OP_LO   = 3;
    localparam int SW_OP_HI   = 5;
    localparam int SW_ADDR_LO = 6;

    // Width of the divider counter and of all divisor arithmetic
    localparam int DIV_W = 32;

    // Divisor for rate index k: the base divisor halved k times, never below 1
    function automatic logic [DIV_W-1:0] rate_div(input logic [DIV_W-1:0] n,
                                                  input int unsigned k);
        logic [DIV_W-1:0] shifted;
        shifted = (k >= DIV_W) ? '0 : (n >> k);
        return (shifted == '0) ? DIV_W'(1) : shifted;
    endfunction

endpackage

// File: rtl/board_ctrl_debounce.sv
// Level debouncer: a new input level is accepted only after it has
// disagreed with the accepted level for DEBOUNCE consecutive cycles.
// rise pulses for one cycle, together with the accepted level going high.
module sw_debounce
    import board_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 200_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    // Counter only needs to reach DEBOUNCE-1; the accepting cycle is the DEBOUNCE-th
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt_reg;
    logic          stable_reg;
    logic          rise_reg;

    // Count disagreeing cycles; flip the accepted level when the run is long enough
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            if (din == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= din;
                cnt_reg    <= '0;
                rise_reg   <= din;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign dout = stable_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/board_ctrl.sv
// Board control front-end: synchronises switches and the step button,
// debounces the rate-step switch and step button, and produces the CPU
// clock-enable pulse from a selectable divider or a single-step request.
module board_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int SW_WIDTH   = 16,
    parameter int ADDR_BITS  = 12,
    parameter int N          = 10_000_000,
    parameter int RATE_COUNT = 4,
    parameter int DEBOUNCE   = 200_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SW_WIDTH-1:0]             sw,
    input  logic                            step_btn,
    output logic                            tick,
    output logic                            go,
    output logic                            cpu_rst,
    output logic [$clog2(RATE_COUNT)-1:0]   rate_sel,
    output logic [2:0]                      display_op,
    output logic [ADDR_BITS-3:0]            ram_display_addr
);

    localparam int RSEL_W = $clog2(RATE_COUNT);
    localparam int SYNC_W = SW_WIDTH + 1;   // all switches plus the step button
    localparam int STEP_BIT = SW_WIDTH;
    localparam logic [RSEL_W-1:0] RATE_LAST = RSEL_W'(RATE_COUNT - 1);

    logic [SYNC_W-1:0] raw_in;
    logic [SYNC_W-1:0] sync_out;

    assign raw_in = {step_btn, sw};

    genvar gi;

    // ------------------------------------------------------------------
    // Two-flop synchroniser, one independent pair per input bit
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < SYNC_W; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;

            // Bring one asynchronous input bit into the clk domain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw_in[gi];
                    s2_reg <= s1_reg;
                end
            end

            assign sync_out[gi] = s2_reg;
        end
    endgenerate

    // Switch bits above the display address field carry no function
    generate
        if (SW_WIDTH > ADDR_BITS + 4) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^sync_out[SW_WIDTH-1:ADDR_BITS+4];
        end
    endgenerate

    // Plain level controls come straight from the synchronised bits
    logic go_s;
    logic cpu_rst_s;

    assign go_s             = sync_out[SW_GO];
    assign cpu_rst_s        = sync_out[SW_RST];
    assign go               = go_s;
    assign cpu_rst          = cpu_rst_s;
    assign display_op       = sync_out[SW_OP_HI:SW_OP_LO];
    assign ram_display_addr = sync_out[SW_ADDR_LO +: ADDR_BITS-2];

    // ------------------------------------------------------------------
    // Debounced rate-step switch and step button
    // ------------------------------------------------------------------
    logic rate_rise;
    logic step_rise;
    logic unused_rate_level;
    logic unused_step_level;

    sw_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_rate_db (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sync_out[SW_RATE]),
        .dout (unused_rate_level),
        .rise (rate_rise)
    );

    sw_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_step_db (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sync_out[STEP_BIT]),
        .dout (unused_step_level),
        .rise (step_rise)
    );

    // ------------------------------------------------------------------
    // Divisor lookup: one constant divisor per selectable rate
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_table [RATE_COUNT];

    generate
        for (gi = 0; gi < RATE_COUNT; gi++) begin : g_div
            assign div_table[gi] = rate_div(DIV_W'(N), gi);
        end
    endgenerate

    logic [RSEL_W-1:0] rate_reg;
    logic [DIV_W-1:0]  cnt_reg;
    logic [DIV_W-1:0]  div_last;
    logic              tick_reg;

    assign div_last = div_table[rate_reg] - DIV_W'(1);

    // Advance the rate index on each accepted rising edge of the rate switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_reg <= '0;
        end else if (rate_rise) begin
            rate_reg <= (rate_reg == RATE_LAST) ? '0 : rate_reg + 1'b1;
        end
    end

    // Divider and tick: CPU reset beats a rate change, which beats terminal count / step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            if (cpu_rst_s) begin
                cnt_reg <= '0;
            end else if (rate_rise) begin
                cnt_reg <= '0;
            end else if (go_s) begin
                if (cnt_reg == div_last) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + DIV_W'(1);
                end
            end else if (step_rise) begin
                // Paused: count holds, an accepted step press gives one tick
                tick_reg <= 1'b1;
            end
        end
    end

    assign tick     = tick_reg;
    assign rate_sel = rate_reg;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl with a small base divisor and short
// debounce so every behaviour is reachable in a few thousand cycles.
module tb_board_ctrl;

    localparam int SWW = 16;
    localparam int AB  = 12;
    localparam int NB  = 16;
    localparam int RC  = 4;
    localparam int DB  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [SWW-1:0] sw = '0;
    logic           step_btn = 1'b0;
    logic           tick;
    logic           go;
    logic           cpu_rst;
    logic [1:0]     rate_sel;
    logic [2:0]     display_op;
    logic [AB-3:0]  ram_display_addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int exp_period [4] = '{8, 4, 2, 16};

    always #5 clk = ~clk;

    board_ctrl #(
        .SW_WIDTH  (SWW),
        .ADDR_BITS (AB),
        .N         (NB),
        .RATE_COUNT(RC),
        .DEBOUNCE  (DB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sw              (sw),
        .step_btn        (step_btn),
        .tick            (tick),
        .go              (go),
        .cpu_rst         (cpu_rst),
        .rate_sel        (rate_sel),
        .display_op      (display_op),
        .ram_display_addr(ram_display_addr)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: inputs are seen two edges late; a level is accepted
    // after DB consecutive disagreeing samples and its rising edge acts one
    // edge later; a running divider ticks every (N>>rate, min 1) cycles.
    // ------------------------------------------------------------------
    logic [SWW:0] m_pipe [2];
    bit           m_level [2];
    int           m_run [2];
    bit           m_evt [2];
    int           m_rate;
    int           m_elapsed;
    bit           m_tick;

    task automatic model_reset();
        m_pipe[0] = '0;
        m_pipe[1] = '0;
        for (int i = 0; i < 2; i++) begin
            m_level[i] = 1'b0;
            m_run[i]   = 0;
            m_evt[i]   = 1'b0;
        end
        m_rate    = 0;
        m_elapsed = 0;
        m_tick    = 1'b0;
    endtask

    task automatic model_step(input logic [SWW:0] smp);
        logic [SWW:0] seen;
        bit rate_evt, step_evt, din;
        int div;
        seen     = m_pipe[1];
        rate_evt = m_evt[0];
        step_evt = m_evt[1];
        for (int i = 0; i < 2; i++) begin
            din = (i == 0) ? seen[2] : seen[SWW];
            m_evt[i] = 1'b0;
            if (din != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] >= DB) begin
                    m_level[i] = din;
                    m_run[i]   = 0;
                    m_evt[i]   = din;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        div = NB >> m_rate;
        if (div < 1) div = 1;
        m_tick = 1'b0;
        if (rate_evt) m_rate = (m_rate + 1) % RC;
        if (seen[1] || rate_evt) begin
            m_elapsed = 0;
        end else if (seen[0]) begin
            m_elapsed++;
            if (m_elapsed == div) begin
                m_tick    = 1'b1;
                m_elapsed = 0;
            end
        end else if (step_evt) begin
            m_tick = 1'b1;
        end
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = smp;
    endtask

    // Compare process: advance the model on every edge and check all outputs
    initial begin : monitor
        logic [SWW:0] smp;
        logic rst_seen;
        model_reset();
        forever begin
            @(posedge clk);
            smp      = {step_btn, sw};
            rst_seen = rst_n;
            cyc++;
            #1;
            if (!rst_seen) begin
                model_reset();
            end else begin
                model_step(smp);
                if (rst_n) begin
                    check("sb_tick", tick, m_tick);
                    check("sb_go", go, m_pipe[1][0]);
                    check("sb_cpu_rst", cpu_rst, m_pipe[1][1]);
                    check("sb_rate_sel", rate_sel, m_rate);
                    check("sb_display_op", display_op, m_pipe[1][5:3]);
                    check("sb_ram_addr", ram_display_addr, m_pipe[1][SWW-1:6]);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tick) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout at cycle %0d: got no tick, expected one within %0d cycles", cyc, limit);
        end
    endtask

    // Directed scenarios with hand-computed expectations, then random stimulus
    initial begin : stim
        int g, t1, t2, c0, n, f;
        rst_n    = 1'b0;
        sw       = '0;
        step_btn = 1'b0;
        cycles(3);
        check("rst_tick", tick, 0);
        check("rst_go", go, 0);
        check("rst_cpu_rst", cpu_rst, 0);
        check("rst_rate_sel", rate_sel, 0);
        check("rst_display_op", display_op, 0);
        check("rst_ram_addr", ram_display_addr, 0);
        rst_n = 1'b1;
        cycles(2);

        // Free run at rate 0
        sw[0] = 1'b1;
        c0 = cyc;
        g = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (go) begin g = cyc; break; end
        end
        check("go_latency", g - c0, 2);
        wait_tick(40, t1);
        check("first_tick_delay", t1 - g, 16);
        wait_tick(40, t2);
        check("period_rate0", t2 - t1, 16);
        check("rate0_sel", rate_sel, 0);

        // Rate steps: 8, 4, 2, then wrap back to 16
        for (int k = 0; k < 4; k++) begin
            sw[2] = 1'b1;
            c0 = cyc;
            n = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rate_sel == 2'((k + 1) % RC)) begin n = cyc; break; end
            end
            check("rate_latency", n - c0, 7);
            wait_tick(40, t1);
            wait_tick(40, t2);
            check("rate_period", t2 - t1, exp_period[k]);
            sw[2] = 1'b0;
            cycles(10);
            check("rate_fall_no_change", rate_sel, (k + 1) % RC);
        end

        // Short glitch on the rate switch
        sw[2] = 1'b1;
        cycles(2);
        sw[2] = 1'b0;
        cycles(12);
        check("glitch_rate_sel", rate_sel, 0);

        // Single step while paused
        sw[0] = 1'b0;
        cycles(6);
        n = 0;
        step_btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 9) step_btn = 1'b0;
            if (tick) n++;
        end
        check("step_tick_count", n, 1);

        // Same press while running: the scoreboard checks there is no extra tick
        sw[0] = 1'b1;
        cycles(4);
        step_btn = 1'b1;
        cycles(10);
        step_btn = 1'b0;
        cycles(20);

        // CPU reset mid-count
        cycles(5);
        sw[1] = 1'b1;
        c0 = cyc;
        n = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_rst) begin n = cyc; break; end
        end
        check("cpu_rst_latency", n - c0, 2);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tick) n++;
        end
        check("tick_during_cpu_rst", n, 0);
        sw[1] = 1'b0;
        f = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!cpu_rst) begin f = cyc; break; end
        end
        wait_tick(40, t1);
        check("period_after_cpu_rst", t1 - f, 16);

        // Randomised switch and button activity
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) sw[0] = ~sw[0];
            if ($urandom_range(0, 59) == 0) sw[1] = ~sw[1];
            if ($urandom_range(0, 5) == 0)  sw[2] = ~sw[2];
            if ($urandom_range(0, 7) == 0)  step_btn = ~step_btn;
            if ($urandom_range(0, 15) == 0) sw[15:3] = 13'($urandom);
        end

        // Make the rate non-zero, then reset asynchronously mid-operation
        sw[1] = 1'b0;
        sw[2] = 1'b0;
        step_btn = 1'b0;
        cycles(12);
        if (rate_sel == 2'd0) begin
            sw[2] = 1'b1;
            cycles(12);
            sw[2] = 1'b0;
            cycles(12);
        end
        sw = {10'h2A5, 3'b101, 3'b001};
        cycles(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tick", tick, 0);
        check("arst_go", go, 0);
        check("arst_cpu_rst", cpu_rst, 0);
        check("arst_rate_sel", rate_sel, 0);
        check("arst_display_op", display_op, 0);
        check("arst_ram_addr", ram_display_addr, 0);
        cycles(3);
        rst_n = 1'b1;
        c0 = cyc;
        n = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_display_addr == 10'h2A5) begin n = cyc; break; end
        end
        check("addr_after_rst_latency", n - c0, 2);
        check("op_after_rst", display_op, 5);
        check("rate_after_rst", rate_sel, 0);
        cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Board-level control front-end sitting between the FPGA switches/buttons and the pipeline CPU top. It synchronises and debounces raw switch and button inputs. It generates a one-cycle CPU clock-enable pulse `tick` at one of `RATE_COUNT` selectable rates, and supports single-step while paused. It also exports the run, reset and display-selection controls. All outputs are in the `clk` domain; the CPU runs on `clk` gated by `tick`, with no derived clocks.

## Interface
- `SW_WIDTH`, 16: raw switch count; must be ≥ `ADDR_BITS`+4.
- `ADDR_BITS`, 12: RAM address width; the display address is `ADDR_BITS`-2 bits.
- `N`, 10_000_000: base divisor (rate 0).
- `RATE_COUNT`, 4: number of selectable rates, ≥2.
- `DEBOUNCE`, 200_000: consecutive stable cycles required to accept a new button/rate-switch level, ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  `SW_WIDTH`  raw switches, asynchronous.
- `step_btn`  in  1  raw single-step button, asynchronous.
- `tick`  out  1  CPU clock-enable, one-cycle pulse.
- `go`  out  1  run (1) / pause (0).
- `cpu_rst`  out  1  CPU reset, active-high level.
- `rate_sel`  out  $clog2(`RATE_COUNT`)  current rate index.
- `display_op`  out  3  display content select.
- `ram_display_addr`  out  `ADDR_BITS`-2  RAM address for display.

## Operation
- Switch map: `sw[0]` go; `sw[1]` cpu_rst; `sw[2]` rate step; `sw[5:3]` display_op; `sw[ADDR_BITS+3:6]` ram_display_addr. Higher bits are ignored.
- All of `sw` and `step_btn` pass through a 2-flop synchroniser. `go`, `cpu_rst`, `display_op` and `ram_display_addr` are driven directly by the synchronised bits.
- Debounce on the synchronised `sw[2]` and `step_btn`:
  - A mismatch counter increments each cycle the input differs from the stable state, and clears when they match.
  - When the counter reaches `DEBOUNCE`, the stable state flips and the counter clears.
- Rate step: a stable-state rising edge of `sw[2]` increments `rate_sel`; `RATE_COUNT`-1 wraps to 0. Falling edges do nothing.
- Divisor for rate k: `div_k = max(N >> k, 1)`. Intermediate arithmetic is 32 bits unsigned.
- Divider counter `cnt`, 0..`div`-1, running while `go`=1:
  - When `cnt == div-1`: `tick`=1 that cycle and `cnt` returns to 0.
  - While `go`=0, `cnt` holds.
- Single step: a stable-state rising edge of `step_btn` while `go`=0 asserts `tick` for exactly one cycle. Steps while `go`=1 are ignored.
- Priority, highest first:
  1. `cpu_rst`=1: `cnt` cleared, `tick`=0, step edges discarded.
  2. Rate change: `cnt` cleared, no tick that cycle, even at terminal count.
  3. Terminal count or single step.
- `go` 0→1: counting resumes from the held `cnt`.

## Timing
- Reset (`rst_n`=0, asynchronous): all outputs 0. `rate_sel`=0, `cnt`=0, synchronisers and debounce states 0.
- Switch to `go`/`cpu_rst`/`display_op`/`ram_display_addr`: 2 cycles.
- Rate switch to `rate_sel`: 2 sync cycles, then `DEBOUNCE` stable cycles, then 1 edge-register cycle.
- Step button to `tick`: 2 + `DEBOUNCE` + 1 cycles; `tick` is high for exactly 1 cycle.
- Free-run period: exactly `div_k` cycles between `tick` pulses. The first tick comes `div_k` cycles after counting starts from 0.
- Glitches shorter than `DEBOUNCE` cycles produce no rate change or step.

## Structure
- Package `board_ctrl_pkg`:
  - switch index constants `SW_GO`, `SW_RST`, `SW_RATE`, `SW_OP_LO`, `SW_OP_HI`, `SW_ADDR_LO`;
  - function `rate_div(n, k)` returning `max(n>>k,1)`.
- Sub-module `sw_debounce` (params `DEBOUNCE`; ports `clk`, `rst_n`, `din`, `dout`, `rise`), instantiated twice.
- Top contains the synchronisers, rate register, divider and tick logic.

## Test plan
Bench parameters: `N`=16, `RATE_COUNT`=4, `DEBOUNCE`=4.

- Reset then `sw[0]`=1: `tick` every 16 cycles, first tick 16 cycles after `go` rises. `rate_sel`=0.
- Toggle `sw[2]` 0→1, held: `rate_sel`=1 after 2+4+1 cycles, and the tick period becomes 8. Further steps give periods 4, then 2, then wrap to 16.
- 2-cycle glitch on `sw[2]`: `rate_sel` unchanged.
- `go`=0, pulse `step_btn` for 10 cycles: exactly one 1-cycle `tick`. The same press with `go`=1 gives no extra tick.
- `sw[1]`=1 mid-count: `cpu_rst`=1 after 2 cycles, no `tick`. On release, the next tick comes a full period later.
- Assert `rst_n`=0 mid-operation: all outputs go to 0 immediately and `rate_sel` returns to 0. `sw[15:6]`=0x2A5 then appears on `ram_display_addr` 2 cycles after release.
